// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: funct3 lane decode, alignment check, and a
// single-outstanding request/ack data-bus cycle with timeout and load extension.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_M,
  input  logic                  i_mem_write_M,
  input  logic [2:0]            i_funct3_M,
  input  logic [DATA_WIDTH-1:0] i_addr_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_stall_M,
  output logic                  o_misaligned,
  output logic                  o_bus_err,
  output logic                  o_bus_cyc,
  output logic                  o_bus_we,
  output logic [DATA_WIDTH-1:0] o_bus_addr,
  output logic [DATA_WIDTH-1:0] o_bus_wdata,
  output logic [3:0]            o_bus_sel,
  input  logic                  i_bus_ack,
  input  logic                  i_bus_err,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // Count value seen in the last BUS cycle that may still complete normally.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [1:0]              addr_lo_q, addr_lo_d;
  logic [2:0]              funct3_q, funct3_d;
  logic                    bus_cyc_q, bus_cyc_d;
  logic                    bus_we_q, bus_we_d;
  logic [DATA_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]              bus_sel_q, bus_sel_d;
  logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
  logic                    bus_err_q, bus_err_d;

  logic                    illegal;
  logic                    misal;
  logic                    access_ok;
  logic [3:0]              sel_dec;
  logic [DATA_WIDTH-1:0]   wdata_dec;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [DATA_WIDTH-1:0]   ld_ext;

  // Decode funct3 into byte lanes, replicated store data and fault flags.
  always_comb begin
    illegal   = 1'b0;
    misal     = 1'b0;
    sel_dec   = 4'b0000;
    wdata_dec = '0;
    case (i_funct3_M[1:0])
      2'b00: begin
        sel_dec   = 4'b0001 << i_addr_M[1:0];
        wdata_dec = {4{i_write_data_M[7:0]}};
      end
      2'b01: begin
        sel_dec   = i_addr_M[1] ? 4'b1100 : 4'b0011;
        wdata_dec = {2{i_write_data_M[15:0]}};
        misal     = i_addr_M[0];
      end
      2'b10: begin
        sel_dec   = 4'b1111;
        wdata_dec = i_write_data_M;
        misal     = |i_addr_M[1:0];
      end
      default: illegal = 1'b1;
    endcase
    // 6/7 never legal; BU/HU have no store form.
    if (i_funct3_M[2] && (i_funct3_M[1] || i_mem_write_M)) begin
      illegal = 1'b1;
    end
  end

  assign access_ok    = ~(illegal | misal);
  assign o_misaligned = (state_q == StIdle) & i_req_M & ~access_ok;
  assign o_stall_M    = ((state_q == StIdle) & i_req_M & access_ok) | (state_q == StBus);

  // Extract and extend the addressed byte/half from the returned word.
  always_comb begin
    ld_byte = '0;
    unique case (addr_lo_q)
      2'd0: ld_byte = i_bus_rdata[7:0];
      2'd1: ld_byte = i_bus_rdata[15:8];
      2'd2: ld_byte = i_bus_rdata[23:16];
      2'd3: ld_byte = i_bus_rdata[31:24];
      default: ld_byte = '0;
    endcase
    ld_half = addr_lo_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = i_bus_rdata;
    endcase
  end

  // Next-state logic for the bus-cycle FSM and its registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    bus_cyc_d   = bus_cyc_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    read_data_d = read_data_q;
    bus_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_req_M && access_ok) begin
          addr_lo_d   = i_addr_M[1:0];
          funct3_d    = i_funct3_M;
          bus_we_d    = i_mem_write_M;
          bus_sel_d   = sel_dec;
          bus_wdata_d = wdata_dec;
          bus_addr_d  = {i_addr_M[DATA_WIDTH-1:2], 2'b00};
          bus_cyc_d   = 1'b1;
          cnt_d       = '0;
          state_d     = StBus;
        end
      end
      StBus: begin
        cnt_d = cnt_q + 1'b1;
        // Error wins over a simultaneous ack.
        if (i_bus_err || (!i_bus_ack && (cnt_q == CntLast))) begin
          read_data_d = '0;
          bus_err_d   = 1'b1;
          bus_cyc_d   = 1'b0;
          state_d     = StDone;
        end else if (i_bus_ack) begin
          if (!bus_we_q) begin
            read_data_d = ld_ext;
          end
          bus_cyc_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        bus_cyc_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any open bus cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_lo_q   <= '0;
      funct3_q    <= '0;
      bus_cyc_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      read_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      bus_cyc_q   <= bus_cyc_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      read_data_q <= read_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign o_bus_cyc     = bus_cyc_q;
  assign o_bus_we      = bus_we_q;
  assign o_bus_addr    = bus_addr_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_bus_sel     = bus_sel_q;
  assign o_read_data_M = read_data_q;
  assign o_bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req_M = 1'b0;
  logic        i_mem_write_M = 1'b0;
  logic [2:0]  i_funct3_M = 3'd0;
  logic [31:0] i_addr_M = '0;
  logic [31:0] i_write_data_M = '0;
  logic [31:0] o_read_data_M;
  logic        o_stall_M;
  logic        o_misaligned;
  logic        o_bus_err;
  logic        o_bus_cyc;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_sel;
  logic        i_bus_ack = 1'b0;
  logic        i_bus_err = 1'b0;
  logic [31:0] i_bus_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  // First-BUS-cycle snapshot and cycle counts of the last access.
  logic        cap_cyc, cap_we;
  logic [3:0]  cap_sel;
  logic [31:0] cap_addr, cap_wdata;
  int          stall_n, bus_n;

  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_M        (i_req_M),
    .i_mem_write_M  (i_mem_write_M),
    .i_funct3_M     (i_funct3_M),
    .i_addr_M       (i_addr_M),
    .i_write_data_M (i_write_data_M),
    .o_read_data_M  (o_read_data_M),
    .o_stall_M      (o_stall_M),
    .o_misaligned   (o_misaligned),
    .o_bus_err      (o_bus_err),
    .o_bus_cyc      (o_bus_cyc),
    .o_bus_we       (o_bus_we),
    .o_bus_addr     (o_bus_addr),
    .o_bus_wdata    (o_bus_wdata),
    .o_bus_sel      (o_bus_sel),
    .i_bus_ack      (i_bus_ack),
    .i_bus_err      (i_bus_err),
    .i_bus_rdata    (i_bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one access at a negedge; ack (with optional err) on BUS cycle ack_at,
  // ack_at=0 means never. Returns positioned at the negedge inside DONE.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int ack_at, input logic err,
                        input logic [31:0] rd);
    i_req_M = 1'b1;
    i_mem_write_M = we;
    i_funct3_M = f3;
    i_addr_M = addr;
    i_write_data_M = wd;
    stall_n = 0;
    bus_n = 0;
    #1;
    if (o_stall_M) stall_n++;
    @(negedge clk);
    cap_cyc = o_bus_cyc;
    cap_we = o_bus_we;
    cap_sel = o_bus_sel;
    cap_addr = o_bus_addr;
    cap_wdata = o_bus_wdata;
    for (int k = 1; k <= 40; k++) begin
      if (!o_stall_M) break;
      bus_n++;
      stall_n++;
      i_bus_ack = (k == ack_at);
      i_bus_err = err && (k == ack_at);
      i_bus_rdata = rd;
      @(negedge clk);
      i_bus_ack = 1'b0;
      i_bus_err = 1'b0;
    end
  endtask

  task automatic finish_done();
    @(negedge clk);
    i_req_M = 1'b0;
    i_mem_write_M = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    @(negedge clk);
    #1;
    check("rst_cyc", {31'b0, o_bus_cyc}, 32'd0);
    check("rst_we", {31'b0, o_bus_we}, 32'd0);
    check("rst_addr", o_bus_addr, 32'd0);
    check("rst_wdata", o_bus_wdata, 32'd0);
    check("rst_sel", {28'b0, o_bus_sel}, 32'd0);
    check("rst_rdata", o_read_data_M, 32'd0);
    check("rst_err", {31'b0, o_bus_err}, 32'd0);
    check("rst_stall", {31'b0, o_stall_M}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // SW, ack on third BUS cycle
    access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 3, 1'b0, 32'h0);
    check("sw_cyc", {31'b0, cap_cyc}, 32'd1);
    check("sw_we", {31'b0, cap_we}, 32'd1);
    check("sw_sel", {28'b0, cap_sel}, 32'hF);
    check("sw_addr", cap_addr, 32'h100);
    check("sw_wdata", cap_wdata, 32'hDEADBEEF);
    check("sw_stall_n", stall_n, 32'd4);
    check("sw_bus_n", bus_n, 32'd3);
    check("sw_done_stall", {31'b0, o_stall_M}, 32'd0);
    check("sw_done_cyc", {31'b0, o_bus_cyc}, 32'd0);
    check("sw_done_err", {31'b0, o_bus_err}, 32'd0);
    finish_done();

    // LB / LBU at lane 3
    access(1'b0, 3'd0, 32'h103, 32'h0, 1, 1'b0, 32'h80123456);
    check("lb_sel", {28'b0, cap_sel}, 32'h8);
    check("lb_addr", cap_addr, 32'h100);
    check("lb_we", {31'b0, cap_we}, 32'd0);
    check("lb_stall_n", stall_n, 32'd2);
    check("lb_data", o_read_data_M, 32'hFFFFFF80);
    finish_done();
    access(1'b0, 3'd4, 32'h103, 32'h0, 1, 1'b0, 32'h80123456);
    check("lbu_data", o_read_data_M, 32'h00000080);
    finish_done();
    access(1'b0, 3'd0, 32'h101, 32'h0, 2, 1'b0, 32'h00007F00);
    check("lb_pos_sel", {28'b0, cap_sel}, 32'h2);
    check("lb_pos_data", o_read_data_M, 32'h0000007F);
    finish_done();

    // LHU / LH upper half, then SH
    access(1'b0, 3'd5, 32'h102, 32'h0, 1, 1'b0, 32'hBEEF1234);
    check("lhu_sel", {28'b0, cap_sel}, 32'hC);
    check("lhu_data", o_read_data_M, 32'h0000BEEF);
    finish_done();
    access(1'b0, 3'd1, 32'h102, 32'h0, 1, 1'b0, 32'hBEEF1234);
    check("lh_data", o_read_data_M, 32'hFFFFBEEF);
    finish_done();
    access(1'b1, 3'd1, 32'h102, 32'h0000ABCD, 1, 1'b0, 32'h11111111);
    check("sh_sel", {28'b0, cap_sel}, 32'hC);
    check("sh_wdata", cap_wdata, 32'hABCDABCD);
    check("sh_keep_rdata", o_read_data_M, 32'hFFFFBEEF);
    finish_done();

    // Faults: misaligned LW, SB with funct3=4, illegal funct3=3
    i_req_M = 1'b1; i_mem_write_M = 1'b0; i_funct3_M = 3'd2; i_addr_M = 32'h102;
    #1;
    check("lw_mis", {31'b0, o_misaligned}, 32'd1);
    check("lw_mis_stall", {31'b0, o_stall_M}, 32'd0);
    @(negedge clk);
    check("lw_mis_cyc", {31'b0, o_bus_cyc}, 32'd0);
    i_mem_write_M = 1'b1; i_funct3_M = 3'd4; i_addr_M = 32'h100;
    #1;
    check("sbu_ill", {31'b0, o_misaligned}, 32'd1);
    check("sbu_stall", {31'b0, o_stall_M}, 32'd0);
    @(negedge clk);
    check("sbu_cyc", {31'b0, o_bus_cyc}, 32'd0);
    i_mem_write_M = 1'b0; i_funct3_M = 3'd3;
    #1;
    check("f3_ill", {31'b0, o_misaligned}, 32'd1);
    i_funct3_M = 3'd2;
    #1;
    check("lw_ok_nomis", {31'b0, o_misaligned}, 32'd0);
    i_req_M = 1'b0;
    @(negedge clk);

    // Timeout
    access(1'b0, 3'd2, 32'h104, 32'h0, 0, 1'b0, 32'h0);
    check("to_bus_n", bus_n, 32'd16);
    check("to_err", {31'b0, o_bus_err}, 32'd1);
    check("to_rdata", o_read_data_M, 32'd0);
    check("to_cyc", {31'b0, o_bus_cyc}, 32'd0);
    finish_done();
    check("to_err_pulse", {31'b0, o_bus_err}, 32'd0);

    // Normal LW, then ack+err together
    access(1'b0, 3'd2, 32'h10C, 32'h0, 1, 1'b0, 32'hCAFEF00D);
    check("lw_data", o_read_data_M, 32'hCAFEF00D);
    finish_done();
    access(1'b0, 3'd2, 32'h108, 32'h0, 2, 1'b1, 32'h12345678);
    check("ackerr_err", {31'b0, o_bus_err}, 32'd1);
    check("ackerr_rdata", o_read_data_M, 32'd0);
    check("ackerr_bus_n", bus_n, 32'd2);
    finish_done();

    // Reset during BUS
    i_req_M = 1'b1; i_mem_write_M = 1'b0; i_funct3_M = 3'd2; i_addr_M = 32'h110;
    @(negedge clk);
    @(negedge clk);
    check("mid_cyc_before", {31'b0, o_bus_cyc}, 32'd1);
    rst = 1'b0;
    i_req_M = 1'b0;
    #1;
    check("mid_cyc", {31'b0, o_bus_cyc}, 32'd0);
    check("mid_stall", {31'b0, o_stall_M}, 32'd0);
    check("mid_addr", o_bus_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(1'b0, 3'd2, 32'h114, 32'h0, 1, 1'b0, 32'h0BADF00D);
    check("post_rst_addr", cap_addr, 32'h114);
    check("post_rst_stall_n", stall_n, 32'd2);
    check("post_rst_data", o_read_data_M, 32'h0BADF00D);
    finish_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit between the pipeline's memory-stage outputs and the external data-memory bus.
- Per access, it:
  - decodes funct3 into byte lanes;
  - checks alignment;
  - runs a single-outstanding request/ack bus cycle with a timeout;
  - stalls the pipeline while the cycle is open;
  - returns sign- or zero-extended load data to the write-back path.

Parameters:
DATA_WIDTH, 32, data/address width; only 32 is supported.
TIMEOUT_CYCLES, 16, number of BUS-state cycles without ack/err before an error is forced.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
i_req_M  in  1  valid load/store in the memory stage
i_mem_write_M  in  1  1=store, 0=load
i_funct3_M  in  3  RV32I width/sign code
i_addr_M  in  32  byte address
i_write_data_M  in  32  store data, right-aligned
o_read_data_M  out  32  extended load data, registered
o_stall_M  out  1  hold IF/ID/EX/MEM
o_misaligned  out  1  alignment or illegal-funct3 fault, combinational
o_bus_err  out  1  one-cycle pulse on bus error or timeout
o_bus_cyc  out  1  bus cycle active
o_bus_we  out  1  bus write enable
o_bus_addr  out  32  word address, bits[1:0]=0
o_bus_wdata  out  32  lane-replicated store data
o_bus_sel  out  4  byte enables
i_bus_ack  in  1  transfer complete
i_bus_err  in  1  transfer error
i_bus_rdata  in  32  read word, valid with ack

Behaviour:
- Reset: state=IDLE. All registered outputs are 0: o_bus_cyc, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_sel, o_read_data_M, o_bus_err. Timeout counter=0.
  - Reset asserted mid-cycle drops o_bus_cyc immediately (async); the access is abandoned.
- Legal funct3 values: 0 (B), 1 (H), 2 (W), 4 (BU), 5 (HU). Stores use only 0/1/2.
- Illegal funct3 values: 3, 6, 7, and 4/5 on a store.
- Alignment rule: H/HU require addr[0]=0; W requires addr[1:0]=0.
- Byte lanes:
  - B: sel = 1<<addr[1:0]; wdata = {4{d[7:0]}}.
  - H: sel = 0011 if addr[1]=0, else 1100; wdata = {2{d[15:0]}}.
  - W: sel = 1111; wdata = d.
- o_misaligned = (state==IDLE) & i_req_M & (misaligned | illegal).
  - No bus cycle and no stall result; the pipeline owns trap handling.
- o_stall_M = (IDLE & i_req_M & legal & aligned) | (state==BUS).
- FSM:
  - IDLE:
    - On legal, aligned i_req_M, latch addr[1:0], funct3, we, sel, wdata and word address.
    - Go to BUS; o_bus_cyc=1 from the next cycle. Counter cleared.
  - BUS:
    - Hold all bus outputs stable. Counter increments each cycle.
    - i_bus_ack: register extracted load data into o_read_data_M (stores leave it unchanged); drop cyc; go to DONE.
    - i_bus_err, or ack-less count reaching TIMEOUT_CYCLES: o_read_data_M=0; o_bus_err=1 for one cycle; drop cyc; go to DONE.
    - ack and err in the same cycle: err wins.
  - DONE:
    - o_stall_M=0 for exactly one cycle so the pipeline advances with o_read_data_M valid.
    - i_req_M is ignored (it is the same, completing instruction).
    - Go to IDLE.
- Latency: with ack on the first BUS cycle, the request is stalled 2 cycles and data is valid in DONE (cycle 3).
- Load extraction: select the byte/half by the latched addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- o_read_data_M holds its value until the next completed load.

Test Plan:
- SW d=0xDEADBEEF at addr 0x100, ack on 3rd BUS cycle -> cyc=1, we=1, sel=1111, bus_addr=0x100, wdata=0xDEADBEEF; stall high 4 cycles, low in DONE.
- LB addr 0x103, rdata=0x80123456 -> sel=1000, o_read_data_M=0xFFFFFF80; LBU at the same address -> 0x00000080.
- LHU addr 0x102, rdata=0xBEEF1234 -> sel=1100, 0x0000BEEF; LH -> 0xFFFFBEEF. SH d=0x0000ABCD at 0x102 -> wdata=0xABCDABCD, sel=1100.
- LW addr 0x102, and SB with funct3=4 -> o_misaligned=1 same cycle, cyc stays 0, stall=0.
- LW with no ack -> exactly TIMEOUT_CYCLES BUS cycles, then bus_err pulse, read_data=0, cyc drops. ack+err simultaneous -> err path.
- rst low in the middle of BUS -> cyc/stall drop immediately, state=IDLE. After release, a new LW completes normally.
